// File: rtl/video_pkg.sv
// Shared video constants and the frame-fetch FSM state type.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package video_pkg;

  localparam int H_ACTIVE   = 1280;
  localparam int V_ACTIVE   = 720;
  localparam int PIXEL_BITS = 16;
  localparam int CHUNK_BITS = 128;
  // One RGB565 frame split into 128-bit chunks (115200).
  localparam int CHUNKS_PER_FRAME = H_ACTIVE * V_ACTIVE * PIXEL_BITS / CHUNK_BITS;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    FLUSH = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_resp_buffer.sv
// Synchronous first-word-fall-through FIFO holding returned DRAM read beats.
// Latency: a write is visible on o_rd_vld/o_rd_dat the cycle after i_wr_vld.
// Backpressure: writes while full are ignored (the caller flags them); reads pop on o_rd_vld && i_rd_rdy.
// Ports: i_clk/i_rst_n clock and async active-low reset; i_wr_vld/i_wr_dat write side;
//        o_rd_vld/i_rd_rdy/o_rd_dat read side; o_full/o_empty/o_count occupancy.
module fetch_resp_buffer #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 128,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_wr_vld,
  input  logic [WIDTH-1:0] i_wr_dat,
  output logic             o_rd_vld,
  input  logic             i_rd_rdy,
  output logic [WIDTH-1:0] o_rd_dat,
  output logic             o_full,
  output logic             o_empty,
  output logic [CNT_W-1:0] o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_wr, w_rd;

  assign o_full   = (r_count == CNT_W'(DEPTH));
  assign o_empty  = (r_count == '0);
  assign o_count  = r_count;
  assign o_rd_vld = !o_empty;
  assign o_rd_dat = r_mem[r_rd_ptr];
  assign w_wr     = i_wr_vld && !o_full;
  assign w_rd     = o_rd_vld && i_rd_rdy;

  always_ff @(posedge i_clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= i_wr_dat;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= (r_wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + PTR_W'(1);
      if (w_rd) r_rd_ptr <= (r_rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + PTR_W'(1);
      r_count <= r_count + CNT_W'(w_wr) - CNT_W'(w_rd);
    end
  end

endmodule

// File: rtl/video_frame_fetcher.sv
// Walks one frame as 128-bit chunks, issues a DRAM read per chunk and streams the returned data out on AXIS.
// Latency: cmd_valid one cycle after entering ISSUE; rd_valid beat -> AXIS tvalid next cycle.
// Backpressure: credit limit MAX_OUTSTANDING plus registered FIFO almost-full gate command issue; read data is never stalled.
// Ports: clk_dram_ctrl/rst_dram_ctrl_n clock and async active-low reset; enable run level;
//        cmd_* read-command handshake; rd_* returned data (no ready); fifo_sender_axis_* output stream and af;
//        frame_done/busy/err_overflow status.
// Build option VIDEO_FETCH_DOUBLE_BUFFER_EN adds base_addr_a/base_addr_b/frame_sel; otherwise BASE_ADDR is the frame base.
module video_frame_fetcher #(
  parameter int                    ADDR_WIDTH       = 27,
  parameter int                    ADDR_STEP        = 8,
  parameter int                    CHUNKS_PER_FRAME = video_pkg::CHUNKS_PER_FRAME,
  parameter int                    MAX_OUTSTANDING  = 8,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR        = '0
) (
  input  logic                  clk_dram_ctrl,
  input  logic                  rst_dram_ctrl_n,
  input  logic                  enable,
`ifdef VIDEO_FETCH_DOUBLE_BUFFER_EN
  input  logic [ADDR_WIDTH-1:0] base_addr_a,
  input  logic [ADDR_WIDTH-1:0] base_addr_b,
  input  logic                  frame_sel,
`endif
  output logic                  cmd_valid,
  input  logic                  cmd_ready,
  output logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic                  rd_valid,
  input  logic [127:0]          rd_data,
  output logic                  fifo_sender_axis_tvalid,
  input  logic                  fifo_sender_axis_tready,
  output logic [127:0]          fifo_sender_axis_tdata,
  output logic                  fifo_sender_axis_tlast,
  input  logic                  fifo_sender_axis_af,
  output logic                  frame_done,
  output logic                  busy,
  output logic                  err_overflow
);

  import video_pkg::*;

  localparam int                IDX_W    = (CHUNKS_PER_FRAME > 1) ? $clog2(CHUNKS_PER_FRAME) : 1;
  localparam int                CRD_W    = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(CHUNKS_PER_FRAME - 1);
  localparam logic [CRD_W-1:0]  CRD_MAX  = CRD_W'(MAX_OUTSTANDING);

  fetch_state_t          r_state, w_state_nxt;
  logic                  r_af_q, r_cmd_valid, r_frame_done, r_err_overflow, w_busy;
  logic [ADDR_WIDTH-1:0] r_cmd_addr, r_frame_base, w_base_sel, w_base;
  logic [IDX_W-1:0]      r_issue_idx, w_issue_idx_nxt, r_out_idx;
  logic [CRD_W-1:0]      r_credits, w_credits_nxt, w_buf_cnt;
  logic                  w_cmd_fire, w_axis_fire, w_cmd_load, w_buf_wr, w_buf_full, w_buf_empty, w_tlast;

`ifdef VIDEO_FETCH_DOUBLE_BUFFER_EN
  assign w_base_sel = frame_sel ? base_addr_b : base_addr_a;
`else
  assign w_base_sel = BASE_ADDR;
`endif

  assign w_cmd_fire      = r_cmd_valid && cmd_ready;
  assign w_axis_fire     = fifo_sender_axis_tvalid && fifo_sender_axis_tready;
  assign w_issue_idx_nxt = !w_cmd_fire ? r_issue_idx :
                           (r_issue_idx == LAST_IDX) ? '0 : r_issue_idx + IDX_W'(1);
  assign w_credits_nxt   = r_credits + CRD_W'(w_cmd_fire) - CRD_W'(w_axis_fire);
  // The base is only resampled for chunk 0, so a frame never mixes two bases.
  assign w_base          = (w_issue_idx_nxt == '0) ? w_base_sel : r_frame_base;

  // A new command is loaded only when the slot is free (or being accepted now), credits
  // stay in range counting this cycle's traffic, and we are not at a frame boundary with
  // enable low (that boundary is where the FSM leaves ISSUE).
  assign w_cmd_load = (r_state == ISSUE) && (!r_cmd_valid || cmd_ready) &&
                      (w_credits_nxt < CRD_MAX) && !r_af_q &&
                      !(!enable && (w_issue_idx_nxt == '0));

  // A beat is only legitimate if some accepted command is still unreturned; with no
  // credits this reduces to credits==0.
  assign w_buf_wr = rd_valid && !w_buf_full && (w_buf_cnt < r_credits);

  always_comb begin
    w_state_nxt = r_state;
    w_busy      = (r_state != IDLE);
    case (r_state)
      IDLE:    if (enable) w_state_nxt = ISSUE;
      ISSUE:   if (!enable && (r_issue_idx == '0) && !r_cmd_valid) w_state_nxt = FLUSH;
      FLUSH: begin
        if (enable)                w_state_nxt = ISSUE;
        else if (r_credits == '0)  w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_dram_ctrl or negedge rst_dram_ctrl_n) begin
    if (!rst_dram_ctrl_n) begin
      r_state        <= IDLE;
      r_af_q         <= 1'b0;
      r_cmd_valid    <= 1'b0;
      r_cmd_addr     <= '0;
      r_frame_base   <= BASE_ADDR;
      r_issue_idx    <= '0;
      r_out_idx      <= '0;
      r_credits      <= '0;
      r_frame_done   <= 1'b0;
      r_err_overflow <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_af_q       <= fifo_sender_axis_af;
      r_issue_idx  <= w_issue_idx_nxt;
      r_credits    <= w_credits_nxt;
      r_frame_done <= w_axis_fire && w_tlast;
      if (rd_valid && !w_buf_wr) r_err_overflow <= 1'b1;
      if (w_axis_fire) r_out_idx <= (r_out_idx == LAST_IDX) ? '0 : r_out_idx + IDX_W'(1);
      if (w_cmd_load) begin
        r_cmd_valid  <= 1'b1;
        r_cmd_addr   <= w_base + ADDR_WIDTH'(w_issue_idx_nxt) * ADDR_WIDTH'(ADDR_STEP);
        r_frame_base <= w_base;
      end else if (w_cmd_fire) begin
        r_cmd_valid  <= 1'b0;
      end
    end
  end

  fetch_resp_buffer #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (128)
  ) u_resp_buf (
    .i_clk    (clk_dram_ctrl),
    .i_rst_n  (rst_dram_ctrl_n),
    .i_wr_vld (w_buf_wr),
    .i_wr_dat (rd_data),
    .o_rd_vld (fifo_sender_axis_tvalid),
    .i_rd_rdy (fifo_sender_axis_tready),
    .o_rd_dat (fifo_sender_axis_tdata),
    .o_full   (w_buf_full),
    .o_empty  (w_buf_empty),
    .o_count  (w_buf_cnt)
  );

  assign w_tlast                = !w_buf_empty && (r_out_idx == LAST_IDX);
  assign fifo_sender_axis_tlast = w_tlast;
  assign cmd_valid              = r_cmd_valid;
  assign cmd_addr               = r_cmd_addr;
  assign frame_done             = r_frame_done;
  assign busy                   = w_busy;
  assign err_overflow           = r_err_overflow;

endmodule

// File: doc/video_frame_fetcher.md
# video_frame_fetcher

Generates the DRAM read-command stream that fills the video read FIFO, in the DRAM-controller clock domain. Walks one 1280x720 RGB565 frame as 128-bit chunks, issues one read command per chunk, and forwards returned data on an AXI-Stream sender port with `tlast` on the final chunk of each frame. Flow control is credit-based, so returned data is never dropped, even though the DRAM read-data port has no backpressure.

## Interface
Parameters:
- `ADDR_WIDTH`, 27: DRAM command address width.
- `ADDR_STEP`, 8: address increment per 128-bit chunk.
- `CHUNKS_PER_FRAME`, 115200: chunks per frame (1280*720*16/128).
- `MAX_OUTSTANDING`, 8: credit limit; also the depth of the internal response buffer.
- `BASE_ADDR`, 0: frame base address when double buffering is compiled out.

Ports:
- `clk_dram_ctrl`  in  1: only clock.
- `rst_dram_ctrl_n`  in  1: reset, asynchronous, active-low.
- `enable`  in  1: level; run continuous frame fetch.
- `base_addr_a`, `base_addr_b`  in  ADDR_WIDTH each: frame bases; present only with `VIDEO_FETCH_DOUBLE_BUFFER_EN`.
- `frame_sel`  in  1: 0 selects A, 1 selects B; present only with the macro.
- `cmd_valid`  out  1 / `cmd_ready`  in  1 / `cmd_addr`  out  ADDR_WIDTH: read-command handshake to the DRAM controller.
- `rd_valid`  in  1 / `rd_data`  in  128: read data returned in command order; no ready signal.
- `fifo_sender_axis_tvalid`  out  1 / `fifo_sender_axis_tready`  in  1 / `fifo_sender_axis_tdata`  out  128 / `fifo_sender_axis_tlast`  out  1: output to the read FIFO.
- `fifo_sender_axis_af`  in  1: FIFO programmable-full.
- `frame_done`  out  1: one-cycle pulse on the handshake of the `tlast` chunk.
- `busy`  out  1: high in any state other than IDLE.
- `err_overflow`  out  1: sticky; cleared only by reset.

## Operation
- Credit definition: `credits` = commands accepted but not yet handshaken out on the AXIS port.
  - +1 on each `cmd_valid && cmd_ready`.
  - −1 on each AXIS handshake.
  - Both in the same cycle: net 0.
  - Range 0..MAX_OUTSTANDING.
- Issue condition: `cmd_valid` = (state==ISSUE) && (credits < MAX_OUTSTANDING) && !af_q, where `af_q` is `fifo_sender_axis_af` registered once.
  - Once `cmd_valid` is raised, it and `cmd_addr` are held stable until `cmd_ready`.
- Addressing: `cmd_addr` = frame_base + issue_idx*ADDR_STEP, computed modulo 2^ADDR_WIDTH (wraps silently).
  - `issue_idx` runs 0..CHUNKS_PER_FRAME-1, then returns to 0.
  - frame_base is latched when `issue_idx` is 0 and the first command of the frame is issued; the base therefore never changes mid-frame.
- Response path: every `rd_valid` beat is written into the response buffer, which drives the AXIS port (first-word-fall-through).
  - `rd_valid` while the buffer is full, or while `credits`==0: the beat is discarded and `err_overflow` is set.
- `tlast`: asserted when `out_idx` == CHUNKS_PER_FRAME-1; `out_idx` increments on each AXIS handshake and wraps to 0.
- FSM:
  - IDLE → ISSUE when `enable`=1.
  - ISSUE → FLUSH when `enable`=0 and `issue_idx`==0 (frame boundary). A drop of `enable` mid-frame has no effect until the frame's last command is issued.
  - FLUSH: no commands issued; → IDLE when `credits`==0.
  - FLUSH → ISSUE when `enable` reasserts.
- Reset values: `cmd_valid` 0, `cmd_addr` 0, AXIS `tvalid` 0, `tlast` 0, `frame_done` 0, `busy` 0, `err_overflow` 0; state IDLE; all counters 0; buffer empty.
- Reset mid-frame: everything is cleared immediately. Partial frames are not resumed; the next frame starts at chunk 0.

## Timing
- Command: `cmd_valid` at the earliest one cycle after the state becomes ISSUE. Back-to-back issue at 1 command/cycle while credits remain.
- af response: a rise of `af` stops issue 2 cycles later (register + issue logic).
  - Up to 2 extra commands may issue, all bounded by credits.
  - The FIFO's programmable-full threshold (12 free) covers MAX_OUTSTANDING+2.
- Data: `rd_valid` beat → AXIS `tvalid` on the next cycle (1-cycle latency, registered write).
- Throughput: 1 chunk/cycle sustained when `tready`=1 and DRAM latency < MAX_OUTSTANDING cycles.
- `frame_done` is asserted in the cycle after the `tlast` handshake.

## Configuration
- `VIDEO_FETCH_DOUBLE_BUFFER_EN` defined:
  - `base_addr_a`, `base_addr_b` and `frame_sel` ports exist.
  - frame_base = `frame_sel` ? B : A, sampled at the frame boundary.
- Undefined: those ports are absent and frame_base = `BASE_ADDR` constant.

## Structure
- Shared package `video_pkg`:
  - constants H_ACTIVE=1280, V_ACTIVE=720, PIXEL_BITS=16, CHUNK_BITS=128, CHUNKS_PER_FRAME;
  - FSM enum `fetch_state_t` (IDLE, ISSUE, FLUSH).
- One sub-module `fetch_resp_buffer`: synchronous FIFO, depth MAX_OUTSTANDING, 128 bits wide, first-word-fall-through, with full/empty and occupancy outputs.

## Test plan
- CHUNKS_PER_FRAME=4, BASE_ADDR=0x100, `cmd_ready`=1, DRAM returns data 3 cycles after each command, `tready`=1 → `cmd_addr` 0x100, 0x108, 0x110, 0x118, 0x100…; `tlast` on every 4th beat; `frame_done` pulse per frame.
- Hold `cmd_ready`=1 and `tready`=0 → exactly 8 commands issue, then `cmd_valid`=0. Set `tready`=1 → issue resumes; no `err_overflow`.
- Raise `af` mid-frame → at most 2 further commands, then none until `af` falls. Data order is preserved.
- Drop `enable` at chunk 1 of 4 → chunks 2 and 3 still issue, then FLUSH. `busy` falls once the last beat drains; no further commands.
- With the macro: `frame_sel` toggles A=0x0 → B=0x8000 mid-frame → change takes effect only at the next chunk-0 address.
- Inject `rd_valid` with `credits`=0 → `err_overflow`=1 and stays 1. Assert reset mid-frame → all outputs return to 0 and the restart begins at the base address.
